// File: rtl/scroll_offset_gen.sv
// Scroll offset generator: once per FRAME_DIV frames, emits a one-cycle write strobe.
// The X/Y offsets then advance by hold, bounce or wrap rules at the edge where the strobe falls.
module scroll_offset_gen #(
  parameter int unsigned XW        = 6,
  parameter int unsigned YW        = 10,
  parameter int unsigned FRAME_DIV = 1
) (
  input  logic          PixelClk2,
  input  logic          Reset,
  input  logic          VSync,
  input  logic          Enable,
  input  logic          Restart,
  input  logic [1:0]    XMode,
  input  logic [1:0]    YMode,
  input  logic [3:0]    XStep,
  input  logic [3:0]    YStep,
  output logic [XW-1:0] XOffsetData,
  output logic [YW-1:0] YOffsetData,
  output logic          OffsetWrite
);

  // The sum must hold offset + a 4-bit step even when the axis is narrower than the step.
  localparam int unsigned XAW = ((XW > 4) ? XW : 4) + 1;
  localparam int unsigned YAW = ((YW > 4) ? YW : 4) + 1;
  localparam logic [XAW-1:0] XMax = XAW'((32'd1 << XW) - 32'd1);
  localparam logic [YAW-1:0] YMax = YAW'((32'd1 << YW) - 32'd1);
  localparam logic [7:0] CntLast = 8'(FRAME_DIV - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StWrite, StUpdate} state_e;

  state_e         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           wr_q, wr_d;
  logic [XW-1:0]  x_off_q, x_off_d, x_nxt, x_dif;
  logic [YW-1:0]  y_off_q, y_off_d, y_nxt, y_dif;
  logic           x_dn_q, x_dn_d, x_nxt_dn;
  logic           y_dn_q, y_dn_d, y_nxt_dn;
  logic [XAW-1:0] x_ext, x_stp, x_sum;
  logic [YAW-1:0] y_ext, y_stp, y_sum;

  // Mode encoding: 0 hold, 1 bounce, 2 wrap-up, 3 wrap-down; direction bit 1 = moving down.
  always_comb begin
    x_ext    = XAW'(x_off_q);
    x_stp    = XAW'(XStep);
    x_sum    = x_ext + x_stp;
    x_dif    = x_off_q - XW'(XStep);
    x_nxt    = x_off_q;
    x_nxt_dn = x_dn_q;
    if (XStep != 4'd0) begin
      case (XMode)
        2'd1: begin
          if (!x_dn_q) begin
            if (x_sum >= XMax) begin
              x_nxt    = '1;
              x_nxt_dn = 1'b1;
            end else begin
              x_nxt = x_sum[XW-1:0];
            end
          end else if (x_ext <= x_stp) begin
            x_nxt    = '0;
            x_nxt_dn = 1'b0;
          end else begin
            x_nxt = x_dif;
          end
        end
        2'd2:    x_nxt = x_sum[XW-1:0];
        2'd3:    x_nxt = x_dif;
        default: ;
      endcase
    end
  end

  always_comb begin
    y_ext    = YAW'(y_off_q);
    y_stp    = YAW'(YStep);
    y_sum    = y_ext + y_stp;
    y_dif    = y_off_q - YW'(YStep);
    y_nxt    = y_off_q;
    y_nxt_dn = y_dn_q;
    if (YStep != 4'd0) begin
      case (YMode)
        2'd1: begin
          if (!y_dn_q) begin
            if (y_sum >= YMax) begin
              y_nxt    = '1;
              y_nxt_dn = 1'b1;
            end else begin
              y_nxt = y_sum[YW-1:0];
            end
          end else if (y_ext <= y_stp) begin
            y_nxt    = '0;
            y_nxt_dn = 1'b0;
          end else begin
            y_nxt = y_dif;
          end
        end
        2'd2:    y_nxt = y_sum[YW-1:0];
        2'd3:    y_nxt = y_dif;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    x_off_d = x_off_q;
    y_off_d = y_off_q;
    x_dn_d  = x_dn_q;
    y_dn_d  = y_dn_q;
    unique case (state_q)
      StIdle: begin
        if (VSync) state_d = StArmed;
      end
      StArmed: begin
        if (!VSync) begin
          state_d = StIdle;
          if (Enable) begin
            if (cnt_q == CntLast) begin
              cnt_d   = 8'd0;
              state_d = StWrite;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
      end
      StWrite: begin
        wr_d    = 1'b1;
        state_d = StUpdate;
      end
      StUpdate: begin
        wr_d    = 1'b0;
        x_off_d = x_nxt;
        y_off_d = y_nxt;
        x_dn_d  = x_nxt_dn;
        y_dn_d  = y_nxt_dn;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (Restart) begin
      state_d = StIdle;
      cnt_d   = 8'd0;
      wr_d    = 1'b0;
      x_off_d = '0;
      y_off_d = '0;
      x_dn_d  = 1'b0;
      y_dn_d  = 1'b0;
    end
  end

  always_ff @(negedge PixelClk2 or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      wr_q    <= 1'b0;
      x_off_q <= '0;
      y_off_q <= '0;
      x_dn_q  <= 1'b0;
      y_dn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      x_off_q <= x_off_d;
      y_off_q <= y_off_d;
      x_dn_q  <= x_dn_d;
      y_dn_q  <= y_dn_d;
    end
  end

  assign XOffsetData = x_off_q;
  assign YOffsetData = y_off_q;
  assign OffsetWrite = wr_q;

endmodule

// File: tb/tb_scroll_offset_gen.sv
// Directed bench for scroll_offset_gen: a default instance plus a FRAME_DIV=3 instance
// share all inputs; hand-computed expectations are checked with immediate assertions.
module tb_scroll_offset_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vs, en, rs;
  logic [1:0] xm, ym;
  logic [3:0] xs, ys;
  logic [5:0] x1, x3;
  logic [9:0] y1, y3;
  logic       w1, w3;
  int tests = 0;
  int fails = 0;
  int p1, p3, acc;

  always #5 clk = ~clk;

  scroll_offset_gen u_dut (
    .PixelClk2(clk), .Reset(rst), .VSync(vs), .Enable(en), .Restart(rs),
    .XMode(xm), .YMode(ym), .XStep(xs), .YStep(ys),
    .XOffsetData(x1), .YOffsetData(y1), .OffsetWrite(w1)
  );

  scroll_offset_gen #(.XW(6), .YW(10), .FRAME_DIV(3)) u_dut3 (
    .PixelClk2(clk), .Reset(rst), .VSync(vs), .Enable(en), .Restart(rs),
    .XMode(xm), .YMode(ym), .XStep(xs), .YStep(ys),
    .XOffsetData(x3), .YOffsetData(y3), .OffsetWrite(w3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One VSync pulse, then enough cycles for the full write/update sequence.
  task automatic frame(output int q1, output int q3);
    q1 = 0;
    q3 = 0;
    @(posedge clk); vs = 1'b1;
    @(posedge clk); vs = 1'b0;
    repeat (4) begin
      @(posedge clk);
      if (w1) q1++;
      if (w3) q3++;
    end
  endtask

  task automatic restart();
    @(posedge clk); rs = 1'b1;
    @(posedge clk); rs = 1'b0;
  endtask

  initial begin
    vs = 1'b0; en = 1'b1; rs = 1'b0;
    xm = 2'd1; ym = 2'd1; xs = 4'd1; ys = 4'd1;
    #1 rst = 1'b1;
    #2;
    check("reset_x", x1, 0);
    check("reset_y", y1, 0);
    check("reset_wr", w1, 0);
    check("reset_x3", x3, 0);
    @(posedge clk); rst = 1'b0;

    acc = 0;
    repeat (6) begin @(posedge clk); if (w1 || w3) acc++; end
    check("no_write_without_vsync", acc, 0);

    // Both axes bounce with step 1: X turns at 63, Y just counts.
    for (int f = 1; f <= 70; f++) begin
      frame(p1, p3);
      check("bounce_x", x1, (f <= 63) ? f : 126 - f);
      check("bounce_y", y1, f);
      check("bounce_pulse", p1, 1);
    end

    restart();
    check("restart_x", x1, 0);
    check("restart_y", y1, 0);

    ym = 2'd0; xm = 2'd2; xs = 4'd15;
    repeat (4) frame(p1, p3);
    check("wrap_to_60", x1, 60);
    xm = 2'd1; xs = 4'd5;
    frame(p1, p3);
    check("bounce_turn_63", x1, 63);
    frame(p1, p3);
    check("bounce_down_58", x1, 58);
    check("hold_y", y1, 0);

    xm = 2'd2; xs = 4'd4;
    frame(p1, p3);
    check("wrap_to_62", x1, 62);
    xs = 4'd3; ym = 2'd3; ys = 4'd2;
    frame(p1, p3);
    check("wrap_up_x", x1, 1);
    check("wrap_down_y", y1, 1022);
    xm = 2'd3; ym = 2'd2; ys = 4'd5;
    frame(p1, p3);
    check("wrap_down_x", x1, 62);
    check("wrap_up_y", y1, 3);
    xm = 2'd1; xs = 4'd0; ym = 2'd3; ys = 4'd0;
    frame(p1, p3);
    check("step0_x", x1, 62);
    check("step0_y", y1, 3);

    restart();
    en = 1'b1;
    acc = 0;
    for (int f = 1; f <= 9; f++) begin
      frame(p1, p3);
      acc += p3;
      check("div3_pulse", p3, (f % 3 == 0) ? 1 : 0);
    end
    check("div3_total", acc, 3);
    en = 1'b0;
    repeat (2) begin
      frame(p1, p3);
      check("div3_disabled", p3, 0);
    end
    en = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      frame(p1, p3);
      check("div3_delayed", p3, (f == 3) ? 1 : 0);
    end

    // Restart sampled while in WRITE cancels the strobe.
    restart();
    xm = 2'd1; ym = 2'd1; xs = 4'd1; ys = 4'd1;
    @(posedge clk); vs = 1'b1;
    @(posedge clk); vs = 1'b0;
    @(posedge clk); rs = 1'b1;
    @(posedge clk); rs = 1'b0;
    check("restart_in_write_wr", w1, 0);
    check("restart_in_write_x", x1, 0);
    acc = 0;
    repeat (3) begin @(posedge clk); if (w1) acc++; end
    check("restart_no_late_write", acc, 0);
    check("restart_no_late_y", y1, 0);

    frame(p1, p3);
    frame(p1, p3);
    check("pre_reset_x", x1, 2);
    check("pre_reset_y", y1, 2);
    @(posedge clk); vs = 1'b1;
    @(posedge clk); vs = 1'b0;
    @(posedge clk);
    @(posedge clk);
    check("strobe_before_reset", w1, 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_wr", w1, 0);
    check("async_reset_x", x1, 0);
    check("async_reset_y", y1, 0);
    @(posedge clk); rst = 1'b0;
    acc = 0;
    repeat (6) begin @(posedge clk); if (w1) acc++; end
    check("post_reset_no_write", acc, 0);
    frame(p1, p3);
    check("post_reset_pulse", p1, 1);
    check("post_reset_x", x1, 1);
    check("post_reset_y", y1, 1);

    // Mode changed while the strobe is high: the value at the UPDATE edge wins.
    xm = 2'd0; ym = 2'd0; xs = 4'd4;
    @(posedge clk); vs = 1'b1;
    @(posedge clk); vs = 1'b0;
    @(posedge clk);
    @(posedge clk);
    check("late_mode_strobe", w1, 1);
    check("late_mode_x_before", x1, 1);
    xm = 2'd2;
    #3;
    check("late_mode_x_stable", x1, 1);
    @(posedge clk);
    check("late_mode_strobe_low", w1, 0);
    check("late_mode_x_after", x1, 5);
    check("late_mode_y_after", y1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scroll_offset_gen.md
SCROLL_OFFSET_GEN -- requirements
Module: scroll_offset_gen

Interface
REQ-001 SHALL have parameter XW, default 6, meaning X offset width in bits (range 1..16).
REQ-002 SHALL have parameter YW, default 10, meaning Y offset width in bits (range 1..16).
REQ-003 SHALL have parameter FRAME_DIV, default 1, meaning the number of VSync falling edges per offset update (range 1..255).
REQ-004 SHALL have port PixelClk2  input  1  single clock; all registers update on the falling edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port VSync  input  1  frame sync, already synchronous to PixelClk2.
REQ-007 SHALL have port Enable  input  1  1 = updates allowed; 0 = frame counting and updates frozen.
REQ-008 SHALL have port Restart  input  1  synchronous return to origin.
REQ-009 SHALL have port XMode  input  2  X axis mode: 0 hold, 1 bounce, 2 wrap-up, 3 wrap-down.
REQ-010 SHALL have port YMode  input  2  Y axis mode, same encoding as XMode.
REQ-011 SHALL have port XStep  input  4  X increment per update (0..15).
REQ-012 SHALL have port YStep  input  4  Y increment per update (0..15).
REQ-013 SHALL have port XOffsetData  output  XW  current X offset, registered.
REQ-014 SHALL have port YOffsetData  output  YW  current Y offset, registered.
REQ-015 SHALL have port OffsetWrite  output  1  one-cycle write strobe; offsets are valid and stable while it is high.

Function
REQ-016 SHALL implement FSM states IDLE, ARMED, WRITE, UPDATE.
REQ-017 SHALL implement IDLE: VSync=1 -> ARMED; otherwise stay in IDLE.
REQ-018 SHALL implement ARMED: VSync=0 and Enable=1 -> frame counter check; VSync=0 and Enable=0 -> IDLE with the counter unchanged; VSync=1 -> stay in ARMED.
REQ-019 SHALL implement the frame counter check: counter=FRAME_DIV-1 -> counter<=0, next state WRITE; otherwise counter<=counter+1, next state IDLE.
REQ-020 SHALL implement WRITE: OffsetWrite<=1, next state UPDATE.
REQ-021 SHALL implement UPDATE: OffsetWrite<=0, offsets and directions <= next values, next state IDLE.
REQ-022 SHALL keep OffsetWrite high for exactly one clock period; offsets change at the same edge OffsetWrite falls, never while it is high.
REQ-023 SHALL meet this latency: edge at which ARMED samples VSync=0 = E0; OffsetWrite rises at E1; new offsets appear at E2.
REQ-024 SHALL sample XMode, YMode, XStep and YStep at the UPDATE edge only.
REQ-025 SHALL implement hold mode: offset unchanged, direction unchanged.
REQ-026 SHALL implement wrap-up mode: offset <= (offset+step) mod 2^W; direction unchanged.
REQ-027 SHALL implement wrap-down mode: offset <= (offset-step) mod 2^W; direction unchanged.
REQ-028 SHALL implement bounce mode, direction up: if offset >= MAX-step then offset<=MAX and direction<=down, else offset<=offset+step (MAX = 2^W-1).
REQ-029 SHALL implement bounce mode, direction down: if offset <= step then offset<=0 and direction<=up, else offset<=offset-step.
REQ-030 SHALL treat step=0 in any mode as no offset change and no direction change.
REQ-031 SHALL compute each axis independently, using one direction bit per axis.
REQ-032 SHALL implement Restart=1 at any edge, in any state: offsets<=0, directions<=up, counter<=0, OffsetWrite<=0, state<=IDLE.
REQ-033 SHALL give Restart priority over every other input.
REQ-034 SHALL let a VSync pulse that arrives while in WRITE or UPDATE be missed only if it ends before IDLE is re-entered; no queueing.
REQ-035 SHALL keep arithmetic at W+1 bits internally, with no overflow into the output.

Reset
REQ-036 SHALL, while Reset=1, asynchronously force state IDLE, counter 0, XOffsetData 0, YOffsetData 0, OffsetWrite 0, both directions up.
REQ-037 SHALL, after Reset deasserts, require a full VSync high->low sequence before the first OffsetWrite.

Verification
REQ-038 SHALL be verified by this scenario: defaults, both modes bounce, steps 1, 70 frames -> X rises 0..63 over frames, stays 63 on the turn frame, then 62; Y increments by 1 per frame; one OffsetWrite per frame.
REQ-039 SHALL be verified by this scenario: XW=6, X bounce, XStep=5, X=60 with direction up -> X=63 with direction down; next update -> 58.
REQ-040 SHALL be verified by this scenario: XMode=2, XStep=3, X=62 -> X=1; XMode=3, XStep=3, X=1 -> X=62.
REQ-041 SHALL be verified by this scenario: FRAME_DIV=3, 9 frames -> exactly 3 OffsetWrite pulses, on frames 3, 6 and 9; Enable=0 for 2 of those frames -> the pulse is delayed by 2 frames.
REQ-042 SHALL be verified by this scenario: Restart asserted during the WRITE cycle -> OffsetWrite stays 0 and offsets read 0 on the next edge; Reset asserted mid-UPDATE -> outputs 0 immediately, with no clock edge needed.
REQ-043 SHALL be verified by this scenario: change XMode while OffsetWrite=1 -> the update uses the value present at the UPDATE edge, and offsets are stable throughout the strobe.
